// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB3 requester: single-outstanding command port to SETUP/ACCESS bus cycles.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states with rsp_err=1.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES out of range 2..255");
  end

  state_e                  state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    accept;
  logic                    done;
  logic                    abort;

  assign accept = (state_q == IDLE) && cmd_valid;
  // PRDATA/PSLVERR are only looked at here, so bus junk outside completion never reaches rsp_*.
  assign done   = (state_q == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign abort = (state_q == ACCESS) && !PREADY && (wait_cnt_q == TMO_LAST);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP)
      wait_cnt_d = 8'd0;
    else if ((state_q == ACCESS) && !PREADY)
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_ff @(posedge PCLK or negedge PRST) begin
    if (!PRST) wait_cnt_q <= 8'd0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = done || abort;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr & ~ADDR_WIDTH'(3);
          pwdata_d = cmd_wdata;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (done) begin
          state_d     = IDLE;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (abort) begin
          state_d     = IDLE;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = PRST && (state_q == IDLE);
    PSELx     = (state_q != IDLE);
    PENABLE   = (state_q == ACCESS);
    PWRITE    = pwrite_q;
    PADDR     = paddr_q;
    PWDATA    = pwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    rsp_rdata = rsp_rdata_q;
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master with a randomized APB slave model.
module tb_apb_master;

  localparam int TMO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          err;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  logic        PCLK, PRST;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRST(PRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  plan_t       slv_q[$];
  exp_t        exp_q[$];
  plan_t       sp;
  exp_t        em;
  bit          cur_open = 0;
  int          acc_cnt = 0;
  logic [31:0] last_rdata = '0;
  bit          last_err = 0;
  bit          prev_rv = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Slave model: wait states, data and error come from the plan of the transfer on the bus.
  always @(negedge PCLK) begin
    if (PSELx && PENABLE && slv_q.size() > 0) begin
      sp = slv_q[0];
      chk("access_paddr", PADDR, sp.addr & ~32'h3);
      chk1("access_pwrite", PWRITE, sp.w);
      if (sp.w) chk("access_pwdata", PWDATA, sp.wdata);
      cur_open = 1;
      if (acc_cnt >= sp.waits) begin
        PREADY  = 1'b1;
        PRDATA  = sp.rdata;
        PSLVERR = sp.err;
        void'(slv_q.pop_front());
        cur_open = 0;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
      end
      acc_cnt++;
    end else begin
      if (cur_open && slv_q.size() > 0) void'(slv_q.pop_front());
      cur_open = 0;
      acc_cnt  = 0;
      if (PSELx && !PENABLE && slv_q.size() > 0) begin
        sp = slv_q[0];
        chk("setup_paddr", PADDR, sp.addr & ~32'h3);
        chk1("setup_pwrite", PWRITE, sp.w);
      end
      PREADY  = 1'($urandom);
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom);
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  always @(negedge PCLK) begin
    if (PRST) begin
      if (rsp_valid) begin
        chk1("rsp_not_consecutive", prev_rv, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          em = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, em.rdata);
          chk1("rsp_err", rsp_err, em.err);
          chk("rsp_cycle", cyc, em.cyc);
          last_rdata = em.rdata;
          last_err   = em.err;
        end
      end else begin
        chk("rsp_rdata_hold", rsp_rdata, last_rdata);
        chk1("rsp_err_hold", rsp_err, last_err);
      end
      prev_rv = rsp_valid;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input logic [31:0] rd, input bit e);
    bit   ok;
    exp_t x;
    ok        = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cmd_accept got cmd_ready=0 for 50 cycles expected acceptance");
    end else begin
      slv_q.push_back('{w: w, addr: a, wdata: d, rdata: rd, waits: waits, err: e});
      if (TMO_EN && waits >= TMO) begin
        x.err = 1; x.rdata = '0; x.cyc = cyc + 2 + TMO;
      end else begin
        x.err = e; x.rdata = w ? 32'h0 : rd; x.cyc = cyc + 3 + waits;
      end
      exp_q.push_back(x);
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge PCLK);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic abort_xfer();
    cmd_valid = 1'b0;
    PRST = 1'b0;
    #1;
    chk1("abort_psel", PSELx, 1'b0);
    chk1("abort_penable", PENABLE, 1'b0);
    chk1("abort_rsp_valid", rsp_valid, 1'b0);
    chk1("abort_cmd_ready", cmd_ready, 1'b0);
    chk("abort_paddr", PADDR, 32'h0);
    void'(exp_q.pop_back());
    slv_q.delete();
    cur_open   = 0;
    acc_cnt    = 0;
    last_rdata = '0;
    last_err   = 0;
    prev_rv    = 0;
    repeat (2) @(posedge PCLK);
    #1;
    PRST = 1'b1;
  endtask

  bit          rw, re;
  int          rwaits, gap;
  logic [31:0] rd;

  initial begin
    PRST = 1'b0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk1("reset_psel", PSELx, 1'b0);
    chk1("reset_penable", PENABLE, 1'b0);
    chk1("reset_pwrite", PWRITE, 1'b0);
    chk("reset_paddr", PADDR, 32'h0);
    chk("reset_pwdata", PWDATA, 32'h0);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk1("reset_cmd_ready", cmd_ready, 1'b0);
    PRST = 1'b1;
    @(negedge PCLK);
    chk1("release_cmd_ready", cmd_ready, 1'b1);
    @(posedge PCLK);
    #1;

    issue(1, 32'h14, 32'hDEADBEEF, 0, 32'h0, 0);
    idle(); drain();

    issue(0, 32'h14, 32'h0, 3, 32'hDEADBEEF, 0);
    idle(); drain();

    for (int i = 0; i < 4; i++) issue(1, 32'(i * 4), $urandom, 0, 32'h0, 0);
    idle(); drain();

    issue(0, 32'h3C, 32'h0, 0, $urandom, 1);
    issue(0, 32'h3C, 32'h0, 0, $urandom, 0);
    idle(); drain();

    issue(0, 32'h20, 32'h0, 3, $urandom, 0);
    idle();
    @(posedge PCLK);
    @(posedge PCLK);
    #2;
    chk1("wait_state_penable", PENABLE, 1'b1);
    abort_xfer();
    issue(1, 32'h24, 32'h12345678, 1, 32'h0, 0);
    idle(); drain();

    issue(0, 32'h34, 32'h0, TMO - 1, $urandom, 0);
    idle(); drain();

    if (TMO_EN) begin
      issue(0, 32'h30, 32'h0, 1000, $urandom, 0);
      idle(); drain();
    end else begin
      issue(0, 32'h30, 32'h0, 1000, $urandom, 0);
      idle();
      repeat (100) @(posedge PCLK);
      #1;
      chk1("stuck_psel", PSELx, 1'b1);
      chk1("stuck_penable", PENABLE, 1'b1);
      abort_xfer();
      @(posedge PCLK);
      #1;
    end

    for (int i = 0; i < 30; i++) begin
      rw     = 1'($urandom);
      rwaits = $urandom_range(0, TMO_EN ? 5 : 3);
      re     = ($urandom_range(0, 3) == 0);
      rd     = $urandom;
      issue(rw, $urandom, $urandom, rwaits, rd, re);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        idle();
        repeat (gap) @(posedge PCLK);
        #1;
      end
    end
    idle(); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
